// File: rtl/key_event_decoder_pkg.sv
// key_event_pkg: state encoding and ms timing helper shared by key_event_decoder
package key_event_pkg;
  typedef enum logic [2:0] {IDLE, HELD, LONG, WAIT2, HELD2} state_t;
  function automatic int ticks_per_ms(input int freq_mhz);
    return freq_mhz * 1000;
  endfunction
endpackage

// File: rtl/key_event_decoder_ms_tick.sv
// key_ms_tick: 1 ms prescaler with synchronous clear; tick is high during the last count
module key_ms_tick #(
  parameter int N = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int PW = $clog2(N > 1 ? N : 2);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  logic [PW-1:0] r_pre, w_nxt;
  logic r_tick;
  always_comb w_nxt = (i_clr || r_pre == LAST) ? '0 : r_pre + 1'b1;
  // tick is registered from the next count so it lines up with r_pre == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_nxt;
      r_tick <= w_nxt == LAST;
    end
  end
  assign o_tick = r_tick;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies key press/release pulses into short, long, double-click events
// and, when KEY_REPEAT_EN is defined, auto-repeat pulses while a long press is held.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 100,
  parameter int MS_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  input  logic key_release,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic busy
);
  state_t r_state, w_next;
  logic [MS_W-1:0] r_ms;
  logic r_short, r_long, r_dbl, r_rep;
  logic w_tick, w_clr, w_p, w_r, w_lhit, w_dhit, w_rhit;
  logic w_short, w_long, w_dbl, w_rep;
  key_ms_tick #(.N(ticks_per_ms(FREQ))) u_tick (
    .clk(clk),
    .rst(rst),
    .i_clr(w_clr),
    .o_tick(w_tick)
  );
  assign w_p = key_press & ~key_release;
  assign w_r = key_release & ~key_press;
  // a threshold is hit on the tick that would carry ms_cnt up to it
  assign w_lhit = w_tick && r_ms == MS_W'(LONG_MS - 1);
  assign w_dhit = w_tick && r_ms == MS_W'(DOUBLE_MS - 1);
`ifdef KEY_REPEAT_EN
  assign w_rhit = w_tick && r_ms == MS_W'(REPEAT_MS - 1);
`else
  assign w_rhit = REPEAT_MS < 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_p ? HELD : IDLE;
      HELD:    w_next = w_r ? WAIT2 : w_lhit ? LONG : HELD;
      LONG:    w_next = w_r ? IDLE : LONG;
      WAIT2:   w_next = w_p ? HELD2 : w_dhit ? IDLE : WAIT2;
      HELD2:   w_next = w_r ? IDLE : HELD2;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy    = r_state != IDLE;
    w_long  = r_state == HELD && !w_r && w_lhit;
    w_short = r_state == WAIT2 && !w_p && w_dhit;
    w_dbl   = r_state == HELD2 && w_r;
    w_rep   = r_state == LONG && !w_r && w_rhit;
    w_clr   = w_next != r_state || w_rep;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms    <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_ms    <= w_clr ? '0 : (w_tick && r_ms != '1) ? r_ms + 1'b1 : r_ms;
      r_short <= w_short;
      r_long  <= w_long;
      r_dbl   <= w_dbl;
      r_rep   <= w_rep;
    end
  end
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_click = r_dbl;
  assign key_repeat   = r_rep;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed timing scenarios plus randomized key traffic against a deadline model
module tb_key_event_decoder;
  localparam int N = 1000, LMS = 4, DMS = 3, RMS = 2;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, key_press = 1'b0, key_release = 1'b0;
  logic short_press, long_press, double_click, key_repeat, busy;
  int errs = 0, checks = 0, cyc = 0;
  int n_short, n_long, n_dbl, n_rep, t_short, t_long, t_dbl, t_rep, t_rise, t_fall;
  logic prev_busy = 1'b0;

  key_event_decoder #(.FREQ(1), .LONG_MS(LMS), .DOUBLE_MS(DMS), .REPEAT_MS(RMS), .MS_W(16)) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
    .short_press(short_press), .long_press(long_press), .double_click(double_click),
    .key_repeat(key_repeat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (short_press) begin n_short++; t_short = cyc; end
    if (long_press) begin n_long++; t_long = cyc; end
    if (double_click) begin n_dbl++; t_dbl = cyc; end
    if (key_repeat) begin n_rep++; t_rep = cyc; end
    if (busy && !prev_busy) t_rise = cyc;
    if (!busy && prev_busy) t_fall = cyc;
    prev_busy = busy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press();
    key_press = 1'b1;
    @(negedge clk);
    key_press = 1'b0;
  endtask
  task automatic release_key();
    key_release = 1'b1;
    @(negedge clk);
    key_release = 1'b0;
  endtask
  task automatic clear_log();
    n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
    t_short = -1; t_long = -1; t_dbl = -1; t_rep = -1; t_fall = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({short_press, long_press, double_click, key_repeat, busy} !== 5'b0) begin
      errs++; $display("FAIL reset_outputs: got %b want 00000", {short_press, long_press, double_click, key_repeat, busy});
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_short();
    int t_entry;
    clear_log();
    press();
    idle(1499);
    release_key();
    t_entry = cyc;
    idle(3100);
    checks++;
    if (n_short !== 1) begin errs++; $display("FAIL short_count: got %0d want 1", n_short); end
    checks++;
    if (t_short !== t_entry + DMS * N) begin errs++; $display("FAIL short_time: got %0d want %0d", t_short, t_entry + DMS * N); end
    checks++;
    if (t_fall !== t_short) begin errs++; $display("FAIL short_busy_fall: got %0d want %0d", t_fall, t_short); end
    checks++;
    if (n_long + n_dbl + n_rep !== 0) begin errs++; $display("FAIL short_other_pulses: got %0d want 0", n_long + n_dbl + n_rep); end
  endtask

  task automatic test_long();
    int tb, exp_rep, exp_trep;
    clear_log();
    press();
    tb = t_rise;
    idle(10499);
    exp_rep = REP_EN ? 3 : 0;
    exp_trep = REP_EN ? tb + LMS * N + 3 * RMS * N : -1;
    checks++;
    if (n_long !== 1) begin errs++; $display("FAIL long_count: got %0d want 1", n_long); end
    checks++;
    if (t_long !== tb + LMS * N) begin errs++; $display("FAIL long_time: got %0d want %0d", t_long, tb + LMS * N); end
    checks++;
    if (n_rep !== exp_rep) begin errs++; $display("FAIL repeat_count: got %0d want %0d", n_rep, exp_rep); end
    checks++;
    if (t_rep !== exp_trep) begin errs++; $display("FAIL repeat_time: got %0d want %0d", t_rep, exp_trep); end
    release_key();
    idle(3100);
    checks++;
    if (n_short + n_dbl !== 0 || n_rep !== exp_rep) begin
      errs++; $display("FAIL long_release_pulses: got short+dbl=%0d rep=%0d want 0 and %0d", n_short + n_dbl, n_rep, exp_rep);
    end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL long_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_double();
    int t_r;
    clear_log();
    press();
    idle(499);
    release_key();
    idle(999);
    press();
    idle(5999);
    release_key();
    t_r = cyc;
    idle(3100);
    checks++;
    if (n_dbl !== 1 || t_dbl !== t_r) begin errs++; $display("FAIL double_click: got n=%0d t=%0d want n=1 t=%0d", n_dbl, t_dbl, t_r); end
    checks++;
    if (n_short + n_long !== 0) begin errs++; $display("FAIL double_other_pulses: got %0d want 0", n_short + n_long); end
    checks++;
    if (t_fall !== t_dbl) begin errs++; $display("FAIL double_busy_fall: got %0d want %0d", t_fall, t_dbl); end
  endtask

  task automatic test_release_at_long_edge();
    int tb;
    clear_log();
    press();
    tb = t_rise;
    idle(LMS * N - 1);
    release_key();
    checks++;
    if (n_long !== 0 || busy !== 1'b1) begin errs++; $display("FAIL race_no_long: got n_long=%0d busy=%b want 0 1", n_long, busy); end
    idle(3100);
    checks++;
    if (n_short !== 1 || t_short !== tb + LMS * N + DMS * N) begin
      errs++; $display("FAIL race_short: got n=%0d t=%0d want n=1 t=%0d", n_short, t_short, tb + LMS * N + DMS * N);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    int tb;
    clear_log();
    key_press = 1'b1;
    key_release = 1'b1;
    @(negedge clk);
    key_press = 1'b0;
    key_release = 1'b0;
    idle(2);
    checks++;
    if (busy !== 1'b0 || n_short + n_long + n_dbl + n_rep !== 0) begin
      errs++; $display("FAIL both_edges_idle: got busy=%b pulses=%0d want 0 0", busy, n_short + n_long + n_dbl + n_rep);
    end
    press();
    idle(1999);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({short_press, long_press, double_click, key_repeat, busy} !== 5'b0) begin
      errs++; $display("FAIL midreset_outputs: got %b want 00000", {short_press, long_press, double_click, key_repeat, busy});
    end
    idle(5);
    clear_log();
    press();
    tb = t_rise;
    idle(4100);
    checks++;
    if (n_long !== 1 || t_long !== tb + LMS * N) begin
      errs++; $display("FAIL restart_long: got n=%0d t=%0d want n=1 t=%0d", n_long, t_long, tb + LMS * N);
    end
    release_key();
    idle(5);
  endtask

  // mode: 0 idle, 1 held, 2 long, 3 wait for second press, 4 second press held
  task automatic test_random();
    int mode, dl, g, act, nx;
    logic p, r, pp, rr, es, el, ed, er;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    dl = 0;
    for (int e = 0; e < 16; e++) begin
      g = $urandom_range(1, 3500);
      act = $urandom_range(0, 4);
      for (int c = 0; c <= g; c++) begin
        p = (c == g) && (act < 2 || act == 4);
        r = (c == g) && act >= 2;
        key_press = p;
        key_release = r;
        pp = p && !r;
        rr = r && !p;
        nx = cyc + 1;
        {es, el, ed, er} = 4'b0;
        case (mode)
          0: if (pp) begin mode = 1; dl = nx + LMS * N; end
          1: if (rr) begin mode = 3; dl = nx + DMS * N; end
             else if (nx == dl) begin el = 1'b1; mode = 2; dl = nx + RMS * N; end
          2: if (rr) mode = 0;
             else if (REP_EN && nx == dl) begin er = 1'b1; dl = nx + RMS * N; end
          3: if (pp) mode = 4;
             else if (nx == dl) begin es = 1'b1; mode = 0; end
          default: if (rr) begin ed = 1'b1; mode = 0; end
        endcase
        @(negedge clk);
        key_press = 1'b0;
        key_release = 1'b0;
        checks++;
        if ({short_press, long_press, double_click, key_repeat, busy} !== {es, el, ed, er, mode != 0}) begin
          errs++; $display("FAIL random_cycle %0d: got %b want %b", cyc, {short_press, long_press, double_click, key_repeat, busy}, {es, el, ed, er, mode != 0});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_release_at_long_edge();
    test_same_cycle_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
